// File: rtl/decode_stage_pipelined_pkg.sv
// decode_stage_pipelined_pkg: RV32I instruction/control types, opcodes and decode helpers
package decode_stage_pipelined_pkg;
    typedef logic [31:0] instruction_type;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
    } control_type;
    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R} imm_format_t;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [2:0] FUNCT3_ADD    = 3'b000;
    localparam logic [2:0] FUNCT3_SR     = 3'b101;
    function automatic imm_format_t get_format(instruction_type inst);
        case (inst[6:0])
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR: return FMT_I;
            OPCODE_STORE:                            return FMT_S;
            OPCODE_BRANCH:                           return FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                return FMT_U;
            OPCODE_JAL:                              return FMT_J;
            default:                                 return FMT_R;
        endcase
    endfunction
    function automatic logic [31:0] gen_imm(instruction_type inst);
        case (get_format(inst))
            FMT_I:   return {{20{inst[31]}}, inst[31:20]};
            FMT_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   return {inst[31:12], 12'b0};
            FMT_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction
    function automatic control_type decode_control(instruction_type inst);
        control_type c;
        c = '0;
        case (inst[6:0])
            OPCODE_LOAD:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; c.alu_op = {1'b0, FUNCT3_ADD}; end
            OPCODE_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
            OPCODE_BRANCH: begin c.branch = 1'b1; c.alu_op = {1'b0, inst[14:12]}; end
            OPCODE_JAL:    begin c.reg_write = 1'b1; c.jump = 1'b1; end
            OPCODE_JALR:   begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; end
            OPCODE_OP_IMM: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = {(inst[14:12] == FUNCT3_SR) & inst[30], inst[14:12]}; end
            OPCODE_OP:     begin c.reg_write = 1'b1; c.alu_op = {inst[30], inst[14:12]}; end
            OPCODE_LUI,
            OPCODE_AUIPC:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
            default:       c = '0;
        endcase
        return c;
    endfunction
    function automatic logic uses_rs2(instruction_type inst);
        return inst[6:0] == OPCODE_OP || inst[6:0] == OPCODE_STORE || inst[6:0] == OPCODE_BRANCH;
    endfunction
endpackage

// File: rtl/decode_stage_pipelined_register_file.sv
// register_file: 2R/1W register file with write-through bypass; x0 reads as zero
module register_file #(
    parameter int XLEN = 32,
    parameter int REG_COUNT = 32,
    localparam int REG_ID_W = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [REG_ID_W-1:0] waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [REG_ID_W-1:0] raddr1_i,
    input  logic [REG_ID_W-1:0] raddr2_i,
    output logic [XLEN-1:0]     rdata1_o,
    output logic [XLEN-1:0]     rdata2_o
);
    logic [XLEN-1:0] regs_q [REG_COUNT];
    logic wr;
    assign wr = we_i && waddr_i != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (wr) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
    assign rdata1_o = (wr && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
    assign rdata2_o = (wr && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
endmodule

// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: RV32I decode with registered ID/EX, handshake, load-use interlock and flush
module decode_stage_pipelined
    import decode_stage_pipelined_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REG_COUNT = 32,
    localparam int REG_ID_W = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                id_ready,
    input  instruction_type     instruction,
    input  logic [XLEN-1:0]     pc,
    input  logic                flush,
    input  logic                RegWrite,
    input  logic [REG_ID_W-1:0] write_id,
    input  logic [XLEN-1:0]     write_data,
    input  logic                ex_ready,
    output logic                id_valid,
    output logic [XLEN-1:0]     data1,
    output logic [XLEN-1:0]     data2,
    output logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     pc_branch,
    output logic [REG_ID_W-1:0] rs1,
    output logic [REG_ID_W-1:0] rs2,
    output logic [REG_ID_W-1:0] rd,
    output control_type         control
);
    logic [REG_ID_W-1:0] rs1_d, rs2_d, rd_d, rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] data1_d, data2_d, imm_d, pcb_d, data1_q, data2_q, imm_q, pcb_q;
    control_type ctrl_d, ctrl_q;
    logic valid_q, adv, hz, load, clear;
    assign rs1_d  = REG_ID_W'(instruction[19:15]);
    assign rs2_d  = REG_ID_W'(instruction[24:20]);
    assign rd_d   = REG_ID_W'(instruction[11:7]);
    assign imm_d  = XLEN'($signed(gen_imm(instruction)));
    assign pcb_d  = pc + imm_d;
    assign ctrl_d = decode_control(instruction);
    register_file #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_rf (
        .clk(clk), .rst(rst), .we_i(RegWrite), .waddr_i(write_id), .wdata_i(write_data),
        .raddr1_i(rs1_d), .raddr2_i(rs2_d), .rdata1_o(data1_d), .rdata2_o(data2_d)
    );
    assign adv = ex_ready | ~valid_q;
    assign hz = valid_q & ctrl_q.mem_read & (rd_q != '0) & if_valid &
                ((rd_q == rs1_d) | (uses_rs2(instruction) & (rd_q == rs2_d)));
    assign id_ready = adv & ~hz & ~rst;
    assign load = adv & ~hz & if_valid & ~flush;
    // every non-loading update (flush, bubble, idle) leaves an all-zero ID/EX
    assign clear = flush | (adv & ~load);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            pcb_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            pcb_q   <= pcb_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end
    assign id_valid  = valid_q;
    assign data1     = data1_q;
    assign data2     = data2_q;
    assign imm       = imm_q;
    assign pc_branch = pcb_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign control   = ctrl_q;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// tb_decode_stage_pipelined: scoreboard bench with directed cases and randomized traffic
module tb_decode_stage_pipelined;
    import decode_stage_pipelined_pkg::*;
    typedef struct packed {
        logic [31:0] d1, d2, imm, pcb;
        logic [4:0]  rs1, rs2, rd;
        control_type c;
    } rec_t;
    localparam logic [31:0] ADDI3  = 32'h00310193;
    localparam logic [31:0] ADD1   = 32'h000000B3;
    localparam logic [31:0] BEQM4  = 32'hFE000EE3;
    localparam logic [31:0] JAL2K  = 32'h0010006F;
    localparam logic [31:0] LW5    = 32'h0000A283;
    localparam logic [31:0] ADD6   = 32'h00128333;
    localparam logic [31:0] SW5    = 32'h00512023;
    localparam logic [31:0] ADDI7  = 32'h00100393;
    logic clk = 1'b0;
    logic rst, if_valid, flush, RegWrite, ex_ready, id_ready, id_valid;
    instruction_type instruction;
    logic [31:0] pc, write_data, data1, data2, imm, pc_branch;
    logic [4:0] write_id, rs1, rs2, rd;
    control_type control;
    int total = 0, bad = 0;
    rec_t sb[$];
    rec_t mon_e;
    logic [31:0] mregs [32];
    logic m_valid, m_load, rdy, hold, r, iv, fl, rw, er;
    logic [4:0] m_rd, wid;
    logic [31:0] cur, pcv, wd;
    logic [6:0] ops [10] = '{OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR,
                              OPCODE_OP_IMM, OPCODE_OP, OPCODE_LUI, OPCODE_AUIPC, 7'h7F};

    always #5 clk = ~clk;

    decode_stage_pipelined dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready), .instruction(instruction),
        .pc(pc), .flush(flush), .RegWrite(RegWrite), .write_id(write_id), .write_data(write_data),
        .ex_ready(ex_ready), .id_valid(id_valid), .data1(data1), .data2(data2), .imm(imm),
        .pc_branch(pc_branch), .rs1(rs1), .rs2(rs2), .rd(rd), .control(control)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        case (i[6:0])
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR: return sx(int'(i[31:20]), 12);
            OPCODE_STORE:  return sx(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
            OPCODE_BRANCH: return sx(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2, 13);
            OPCODE_LUI, OPCODE_AUIPC: return 32'(i[31:12]) * 32'd4096;
            OPCODE_JAL:    return sx(int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2, 21);
            default:       return 32'd0;
        endcase
    endfunction

    function automatic control_type m_ctrl(input logic [31:0] i);
        control_type c;
        logic [6:0] op;
        logic [2:0] f3;
        c = '0;
        op = i[6:0];
        f3 = i[14:12];
        if (op == OPCODE_LOAD)   begin c.reg_write = 1; c.mem_read = 1; c.mem_to_reg = 1; c.alu_src = 1; end
        if (op == OPCODE_STORE)  begin c.mem_write = 1; c.alu_src = 1; end
        if (op == OPCODE_BRANCH) begin c.branch = 1; c.alu_op = {1'b0, f3}; end
        if (op == OPCODE_JAL)    begin c.reg_write = 1; c.jump = 1; end
        if (op == OPCODE_JALR)   begin c.reg_write = 1; c.jump = 1; c.alu_src = 1; end
        if (op == OPCODE_OP_IMM) begin c.reg_write = 1; c.alu_src = 1; c.alu_op = {f3 == 3'd5 && i[30], f3}; end
        if (op == OPCODE_OP)     begin c.reg_write = 1; c.alu_op = {i[30], f3}; end
        if (op == OPCODE_LUI || op == OPCODE_AUIPC) begin c.reg_write = 1; c.alu_src = 1; end
        return c;
    endfunction

    function automatic logic uses2(input logic [31:0] i);
        return i[6:0] == OPCODE_OP || i[6:0] == OPCODE_STORE || i[6:0] == OPCODE_BRANCH;
    endfunction

    task automatic step(input logic sr, input logic siv, input logic [31:0] ins, input logic [31:0] spc,
                        input logic sfl, input logic srw, input logic [4:0] swid, input logic [31:0] swd,
                        input logic ser, output logic srdy);
        logic adv, hz, acc;
        rec_t e;
        e = '0;
        rst = sr; if_valid = siv; instruction = ins; pc = spc; flush = sfl;
        RegWrite = srw; write_id = swid; write_data = swd; ex_ready = ser;
        @(negedge clk);
        adv = ser | ~m_valid;
        hz = m_valid & m_load & (m_rd != 0) & siv & ((m_rd == ins[19:15]) | (uses2(ins) & (m_rd == ins[24:20])));
        srdy = id_ready;
        chk("id_ready", 32'(id_ready), 32'(adv & ~hz & ~sr));
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        acc = adv & ~hz & siv & ~sfl & ~sr;
        if (acc) begin
            e.rs1 = ins[19:15];
            e.rs2 = ins[24:20];
            e.rd  = ins[11:7];
            e.d1  = (srw && swid != 0 && swid == e.rs1) ? swd : mregs[e.rs1];
            e.d2  = (srw && swid != 0 && swid == e.rs2) ? swd : mregs[e.rs2];
            e.imm = m_imm(ins);
            e.pcb = spc + e.imm;
            e.c   = m_ctrl(ins);
        end
        @(posedge clk);
        if (acc) sb.push_back(e);
        m_valid = (sr | sfl) ? 1'b0 : adv ? acc : m_valid;
        if (sr | sfl | adv) begin
            m_load = acc & e.c.mem_read;
            m_rd   = acc ? e.rd : 5'd0;
        end
        if (sr) for (int k = 0; k < 32; k++) mregs[k] = 0;
        else if (srw && swid != 0) mregs[swid] = swd;
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] spc);
        step(1'b0, 1'b1, ins, spc, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rdy);
    endtask

    task automatic wb(input logic [4:0] id, input logic [31:0] d);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, id, d, 1'b1, rdy);
    endtask

    always @(negedge clk) begin
        if (id_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got id_valid=1 want no pending instruction");
            end else begin
                mon_e = sb[0];
                chk("sb_data1", data1, mon_e.d1);
                chk("sb_data2", data2, mon_e.d2);
                chk("sb_imm", imm, mon_e.imm);
                chk("sb_pc_branch", pc_branch, mon_e.pcb);
                chk("sb_rs1", 32'(rs1), 32'(mon_e.rs1));
                chk("sb_rs2", 32'(rs2), 32'(mon_e.rs2));
                chk("sb_rd", 32'(rd), 32'(mon_e.rd));
                chk("sb_control", 32'(control), 32'(mon_e.c));
                if (ex_ready | flush | rst) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1; if_valid = 0; instruction = 0; pc = 0; flush = 0;
        RegWrite = 0; write_id = 0; write_data = 0; ex_ready = 1;
        m_valid = 0; m_load = 0; m_rd = 0; hold = 0; cur = 0; pcv = 0;
        for (int k = 0; k < 32; k++) mregs[k] = 0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rdy);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_data1", data1, 32'd0);
        chk("rst_control", 32'(control), 32'd0);
        wb(5'd2, 32'd5);
        issue(ADDI3, 32'd0);
        chk("addi_valid", 32'(id_valid), 32'd1);
        chk("addi_data1", data1, 32'd5);
        chk("addi_imm", imm, 32'd3);
        chk("addi_rd", 32'(rd), 32'd3);
        chk("addi_rs1", 32'(rs1), 32'd2);
        step(1'b0, 1'b1, ADDI3, 32'd0, 1'b0, 1'b1, 5'd2, 32'd9, 1'b1, rdy);
        chk("bypass_data1", data1, 32'd9);
        wb(5'd0, 32'hDEADBEEF);
        issue(ADD1, 32'd0);
        chk("x0_data1", data1, 32'd0);
        chk("x0_data2", data2, 32'd0);
        issue(BEQM4, 32'h100);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_target", pc_branch, 32'hFC);
        issue(JAL2K, 32'hFFFFF800);
        chk("jal_imm", imm, 32'h800);
        chk("jal_wrap", pc_branch, 32'd0);
        issue(LW5, 32'd0);
        issue(ADD6, 32'd0);
        chk("lu_stall", 32'(rdy), 32'd0);
        chk("lu_bubble", 32'(id_valid), 32'd0);
        issue(ADD6, 32'd0);
        chk("lu_resume", 32'(rdy), 32'd1);
        chk("lu_add_rd", 32'(rd), 32'd6);
        issue(LW5, 32'd0);
        issue(SW5, 32'd0);
        chk("sw_stall", 32'(rdy), 32'd0);
        issue(SW5, 32'd0);
        chk("sw_resume", 32'(rdy), 32'd1);
        issue(LW5, 32'd0);
        issue(ADDI7, 32'd0);
        chk("addi7_nostall", 32'(rdy), 32'd1);
        chk("addi7_rd", 32'(rd), 32'd7);
        issue(ADDI3, 32'd0);
        repeat (3) begin
            step(1'b0, 1'b1, ADD1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, rdy);
            chk("bp_ready", 32'(rdy), 32'd0);
            chk("bp_hold_rd", 32'(rd), 32'd3);
        end
        issue(ADD1, 32'd0);
        chk("bp_release_rd", 32'(rd), 32'd1);
        step(1'b0, 1'b1, ADDI3, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, rdy);
        chk("flush_valid", 32'(id_valid), 32'd0);
        issue(LW5, 32'd0);
        step(1'b1, 1'b1, ADD6, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rdy);
        chk("mrst_valid", 32'(id_valid), 32'd0);
        chk("mrst_rd", 32'(rd), 32'd0);
        chk("mrst_control", 32'(control), 32'd0);
        issue(ADD6, 32'd0);
        chk("mrst_ready", 32'(rdy), 32'd1);
        chk("mrst_accept", 32'(id_valid), 32'd1);
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                cur = $urandom;
                cur[6:0] = ops[$urandom_range(0, 9)];
                cur[11:7] = 5'($urandom_range(0, 7));
                cur[19:15] = 5'($urandom_range(0, 7));
                cur[24:20] = 5'($urandom_range(0, 7));
                pcv = $urandom;
            end
            iv = hold | ($urandom_range(0, 9) < 8);
            fl = $urandom_range(0, 19) == 0;
            r = $urandom_range(0, 99) == 0;
            er = $urandom_range(0, 3) != 0;
            rw = 1'($urandom_range(0, 1));
            wid = 5'($urandom_range(0, 7));
            wd = $urandom;
            step(r, iv, cur, pcv, fl, rw, wid, wd, er, rdy);
            hold = iv & ~rdy & ~fl & ~r;
        end
        repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, rdy);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised successor to the single-cycle decode stage. It adds a registered ID/EX output with a valid/ready handshake, a load-use hazard interlock, a flush input and write-through bypass on the register file. It sits between the fetch stage and the execute stage of the RISC-V pipeline and decodes RV32I I/S/B/U/J/R formats.

Parameters:
XLEN, 32, datapath width of registers, pc, immediates and branch target
REG_COUNT, 32, number of architectural registers; x0 is hardwired to zero
REG_ID_W, $clog2(REG_COUNT), register index width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
if_valid  input  1  fetch presents a valid instruction
id_ready  output  1  decode accepts the instruction this cycle
instruction  input  instruction_type  fetched instruction
pc  input  XLEN  pc of that instruction
flush  input  1  kill the instruction being accepted and the ID/EX contents
RegWrite  input  1  writeback enable
write_id  input  REG_ID_W  writeback register
write_data  input  XLEN  writeback data
ex_ready  input  1  execute accepts the ID/EX contents
id_valid  output  1  ID/EX register holds a valid instruction
data1, data2  output  XLEN  operand values
imm  output  XLEN  sign-extended immediate
pc_branch  output  XLEN  pc + imm
rs1, rs2, rd  output  REG_ID_W  register indices
control  output  control_type  decoded control bundle

Behaviour:
- Reset (rst=1 at a clk edge): id_valid=0, all ID/EX outputs 0, control=0, all registers 0. Reset wins over every other input, including a reset asserted mid-stall.
- Register file: written on clk when RegWrite=1 and write_id!=0. Writes to x0 are ignored.
  - Reads are combinational.
  - Bypass: if RegWrite=1, write_id!=0 and write_id equals the rs being read, the read returns write_data in the same cycle.
- Decode is combinational from instruction and registered into ID/EX. Latency is 1 cycle from acceptance to id_valid.
- Immediates by opcode:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - All are sign-extended to XLEN. R-type imm=0.
- pc_branch = pc + imm, computed modulo 2^XLEN (wraps).
- Advance condition: adv = ex_ready | ~id_valid.
- Load-use hazard: hz = id_valid & control.MemRead & rd!=0 & if_valid & (rd==rs1_in | (uses_rs2 & rd==rs2_in)). uses_rs2 holds for R, S and B formats.
- id_ready = adv & ~hz & ~rst.
- Per-cycle priority for the ID/EX update:
  1. rst
  2. flush: id_valid<=0 and the incoming instruction is dropped. id_ready follows the formula above.
  3. adv & hz: insert a bubble, id_valid<=0 with all other fields zeroed. The fetch input is held.
  4. adv & if_valid: load the decoded instruction, id_valid<=1.
  5. adv & ~if_valid: id_valid<=0.
  6. ~adv: hold every output unchanged.
- A hazard lasts exactly one bubble cycle. In the next cycle the load has moved to EX, id_valid=0 and the instruction is accepted.
- Unknown opcode: decoded as a NOP bubble, control=0, id_valid=1, no exception raised.
- Simultaneous writeback and decode of the same rs: the bypass value is captured.

Decomposition:
- In common package: instruction_type; control_type, extended with a MemRead field if absent; OPCODE_*/FUNCT3_* constants; imm_format_t enum (I,S,B,U,J,R).
- Sub-module register_file, parameterised XLEN/REG_COUNT: two read ports, one write port, bypass, x0 hardwired to zero.
- Immediate generation and control decoding stay as functions in the package.

Test Plan:
- Reset, bypass, ADDI. rst high for 1 cycle; write x2=5 via RegWrite. Then ADDI x3,x2,3 (0x00310193) with if_valid=1, ex_ready=1. Expected: next cycle id_valid=1, data1=5, imm=3, rd=3, rs1=2. A write of x2=9 in the same cycle as decode gives data1=9 (bypass).
- x0 hardwiring. Write x0=0xDEADBEEF, then decode ADD x1,x0,x0. Expected: data1=data2=0.
- Immediate sign-extension and branch wrap. BEQ with offset -4 at pc=0x100 gives imm=0xFFFFFFFC, pc_branch=0xFC. JAL +2048 at pc=0xFFFFF800 gives pc_branch=0 (wrap).
- Load-use interlock. LW x5,0(x1) accepted, then ADD x6,x5,x1 presented. Expected: id_ready=0 for exactly 1 cycle, one bubble (id_valid=0), then ADD appears with id_valid=1. An SW with rs2=x5 also stalls; an ADDI x7,x0,1 does not stall.
- Downstream backpressure. ex_ready=0 for 3 cycles while valid: all outputs held stable, id_ready=0. When ex_ready returns to 1, the next instruction loads in 1 cycle.
- Flush and mid-stall reset.
  - flush=1 with an instruction presented: id_valid=0 next cycle.
  - rst asserted during a load-use stall: all outputs 0 and id_valid=0 after the edge, with no stale bubble count afterwards.
